// File: rtl/oper_order_exp_diff.sv
// Operand-ordering stage behind the magnitude comparator. It registers major/minor operands and the exponent difference
// in a 2-entry elastic buffer. Optional macro EXP_DIFF_SAT_EN clamps exp_diff to SW+3.
//
// state | meaning
// EMPTY | no entry held; head outputs invalid
// ONE   | head holds the oldest entry, skid empty
// FULL  | head and skid both hold entries; input stalled
module oper_order_exp_diff #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  Data_X,
  input  logic [W-1:0]  Data_Y,
  input  logic          gthan,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  major_op,
  output logic [W-1:0]  minor_op,
  output logic [EW-1:0] exp_diff,
  output logic          swap_flag
);

  localparam int ENT_W = 2*W + EW + 1;
  localparam logic [EW-1:0] SAT_LIM = EW'(SW + 3);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [ENT_W-1:0] head_q, skid_q, new_ent;
  logic             head_load_new, head_load_skid, skid_load;

  logic             swap;
  logic [W-1:0]     major_c, minor_c;
  logic [EW-1:0]    diff_raw, diff_c;
  logic             in_xfer, out_xfer;

  // A tie keeps X as major so equal operands never report a swap.
  assign swap     = ~gthan & (Data_Y[W-2:0] != Data_X[W-2:0]);
  assign major_c  = swap ? Data_Y : Data_X;
  assign minor_c  = swap ? Data_X : Data_Y;
  assign diff_raw = major_c[W-2:SW] - minor_c[W-2:SW];

`ifdef EXP_DIFF_SAT_EN
  assign diff_c = (diff_raw > SAT_LIM) ? SAT_LIM : diff_raw;
`else
  assign diff_c = diff_raw;
`endif

  assign new_ent  = {major_c, minor_c, diff_c, swap};

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    head_load_new  = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d       = ONE;
          head_load_new = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (out_xfer && !in_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer && out_xfer) begin
          head_load_new = 1'b1;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d        = ONE;
          head_load_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (head_load_new)
        head_q <= new_ent;
      else if (head_load_skid)
        head_q <= skid_q;
      if (skid_load)
        skid_q <= new_ent;
    end
  end

  assign major_op  = head_q[ENT_W-1 -: W];
  assign minor_op  = head_q[EW+W   -: W];
  assign exp_diff  = head_q[EW     -: EW];
  assign swap_flag = head_q[0];

endmodule
